decode_stage: RTL and testbench

- Registered instruction-decode pipeline stage between fetch and execute, replacing the flat combinational opcode-to-type lookup.
- Classifies the opcode field into instruction type (R/I/J/B) and a finer class.
- Splits CALL into two micro-ops and flags illegal opcodes.
- Handshakes with valid/ready on both sides and keeps a count of retired decodes.

---
 rtl/decode_pkg.sv | 38 +++
 rtl/decode_if.sv | 31 +++
 rtl/opcode_classify.sv | 48 ++++
 rtl/decode_stage.sv | 134 +++++++++++++
 tb/tb_decode_stage.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction type codes, class enum, opcode constants
// and the decode-stage FSM state type.
package decode_pkg;

  localparam logic [1:0] TYPE_R = 2'b00;
  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_J = 2'b10;
  localparam logic [1:0] TYPE_B = 2'b11;

  typedef enum logic [2:0] {
    CLS_ALU  = 3'd0,
    CLS_LD   = 3'd1,
    CLS_ST   = 3'd2,
    CLS_IMM  = 3'd3,
    CLS_JMP  = 3'd4,
    CLS_CALL = 3'd5,
    CLS_RET  = 3'd6,
    CLS_BR   = 3'd7
  } cls_e;

  localparam logic [3:0] OPC_ALU  = 4'b0001;
  localparam logic [3:0] OPC_IMM  = 4'b0010;
  localparam logic [3:0] OPC_JMP  = 4'b0011;
  localparam logic [3:0] OPC_BR   = 4'b0100;
  localparam logic [3:0] OPC_LD   = 4'b0101;
  localparam logic [3:0] OPC_ST   = 4'b0110;
  localparam logic [3:0] OPC_CALL = 4'b0111;
  localparam logic [3:0] OPC_RET  = 4'b1000;
  localparam logic [3:0] OPC_ALU2 = 4'b1001;
  localparam logic [3:0] OPC_ALU3 = 4'b1010;
  localparam logic [3:0] OPC_ALU4 = 4'b1011;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CALL2 = 1'b1
  } state_e;

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave: the decode stage itself; master: the surrounding pipeline.
interface decode_if #(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [1:0]         out_type;
  logic [2:0]         out_cls;
  logic               out_uop;
  logic               illegal_o;
  logic               trap_o;
  logic [CNT_W-1:0]   dec_count;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, out_type, out_cls, out_uop,
           illegal_o, trap_o, dec_count
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_type, out_cls, out_uop,
           illegal_o, trap_o, dec_count
  );
endinterface

// File: rtl/opcode_classify.sv
// Combinational opcode classifier: opcode -> type, class, illegal flag.
// Shared with the hazard unit, so it carries no state.
module opcode_classify
  import decode_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] i_opc,
  output logic [1:0]       o_type,
  output cls_e             o_cls,
  output logic             o_illegal
);

  logic w_hi;

  // Opcode bits above the 4-bit decoded field make the opcode illegal when present
  generate
    if (OPC_W > 4) begin : g_hi
      assign w_hi = |i_opc[OPC_W-1:4];
    end else begin : g_nohi
      assign w_hi = 1'b0;
    end
  endgenerate

  // Table lookup on the low opcode nibble; unknown codes fall back to ALU and flag illegal
  always_comb begin
    o_type    = TYPE_R;
    o_cls     = CLS_ALU;
    o_illegal = 1'b0;
    case (i_opc[3:0])
      OPC_ALU, OPC_ALU2, OPC_ALU3, OPC_ALU4: begin o_type = TYPE_R; o_cls = CLS_ALU;  end
      OPC_LD:   begin o_type = TYPE_R; o_cls = CLS_LD;   end
      OPC_ST:   begin o_type = TYPE_R; o_cls = CLS_ST;   end
      OPC_IMM:  begin o_type = TYPE_I; o_cls = CLS_IMM;  end
      OPC_JMP:  begin o_type = TYPE_J; o_cls = CLS_JMP;  end
      OPC_CALL: begin o_type = TYPE_J; o_cls = CLS_CALL; end
      OPC_RET:  begin o_type = TYPE_J; o_cls = CLS_RET;  end
      OPC_BR:   begin o_type = TYPE_B; o_cls = CLS_BR;   end
      default:  o_illegal = 1'b1;
    endcase
    if (w_hi) begin
      o_type    = TYPE_R;
      o_cls     = CLS_ALU;
      o_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready on both sides.
// CALL is split into two micro-ops (push, then jump) via a RUN/CALL2 FSM.
// Optional build macro DECODE_ILLEGAL_TRAP_EN: illegal opcodes are dropped and
// raise a one-cycle trap_o pulse instead of being forwarded with illegal_o=1.
module decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush_i,
  decode_if.slave   bus
);

  state_e             r_state, w_state_nxt;
  logic               r_valid, w_valid_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic [1:0]         r_type,  w_type_nxt;
  cls_e               r_cls,   w_cls_nxt;
  logic               r_uop,   w_uop_nxt;
  logic               r_ill,   w_ill_nxt;
  logic               r_trap,  w_trap_nxt;
  logic [CNT_W-1:0]   r_cnt;

  logic [1:0] w_type;
  cls_e       w_cls;
  logic       w_ill;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_consume;
  logic       w_fwd;

  opcode_classify #(.OPC_W(OPC_W)) u_classify (
    .i_opc     (bus.in_instr[INSTR_W-1 -: OPC_W]),
    .o_type    (w_type),
    .o_cls     (w_cls),
    .o_illegal (w_ill)
  );

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign w_fwd = !w_ill;
`else
  assign w_fwd = 1'b1;
`endif

  assign w_in_ready = (!r_valid || bus.out_ready) && (r_state == ST_RUN) && !flush_i;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_consume  = r_valid && bus.out_ready && !flush_i;

  // Next-state and next-bundle selection; flush dominates, CALL2 replays with uop=1
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_instr_nxt = r_instr;
    w_type_nxt  = r_type;
    w_cls_nxt   = r_cls;
    w_uop_nxt   = r_uop;
    w_ill_nxt   = r_ill;
    w_trap_nxt  = 1'b0;
    if (flush_i) begin
      w_valid_nxt = 1'b0;
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_CALL2: begin
          if (bus.out_ready) begin
            w_uop_nxt   = 1'b1;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          if (w_accept) begin
            w_valid_nxt = w_fwd;
            w_trap_nxt  = !w_fwd;
            if (w_fwd) begin
              w_instr_nxt = bus.in_instr;
              w_type_nxt  = w_type;
              w_cls_nxt   = w_cls;
              w_uop_nxt   = 1'b0;
              w_ill_nxt   = w_ill;
              if (w_cls == CLS_CALL) w_state_nxt = ST_CALL2;
            end
          end else if (bus.out_ready) begin
            w_valid_nxt = 1'b0;
          end
        end
      endcase
    end
  end

  // State and output bundle registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_type  <= TYPE_R;
      r_cls   <= CLS_ALU;
      r_uop   <= 1'b0;
      r_ill   <= 1'b0;
      r_trap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_instr <= w_instr_nxt;
      r_type  <= w_type_nxt;
      r_cls   <= w_cls_nxt;
      r_uop   <= w_uop_nxt;
      r_ill   <= w_ill_nxt;
      r_trap  <= w_trap_nxt;
    end
  end

  // Retired-decode counter, one count per consumed micro-op, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (w_consume) r_cnt <= r_cnt + 1'b1;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_instr = r_instr;
  assign bus.out_type  = r_type;
  assign bus.out_cls   = r_cls;
  assign bus.out_uop   = r_uop;
  assign bus.illegal_o = r_ill;
  assign bus.trap_o    = r_trap;
  assign bus.dec_count = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a queue scoreboard of expected bundles.
module tb_decode_stage;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 4;
  localparam int CNT_W   = 4;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] instr;
    logic [1:0]  typ;
    logic [2:0]  cls;
    logic        uop;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;
  always #5 clk = ~clk;

  decode_if #(.INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

  decode_stage #(.INSTR_W(INSTR_W), .OPC_W(OPC_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .bus     (bus)
  );

  exp_t             q[$];
  int               total = 0;
  int               bad = 0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_trap = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_dec(input logic [15:0] ins);
    exp_t e;
    e.instr = ins; e.uop = 1'b0; e.ill = 1'b0; e.typ = 2'd0; e.cls = 3'd0;
    case (ins[15:12])
      4'h1, 4'h9, 4'hA, 4'hB: begin e.typ = 2'd0; e.cls = 3'd0; end
      4'h5: begin e.typ = 2'd0; e.cls = 3'd1; end
      4'h6: begin e.typ = 2'd0; e.cls = 3'd2; end
      4'h2: begin e.typ = 2'd1; e.cls = 3'd3; end
      4'h3: begin e.typ = 2'd2; e.cls = 3'd4; end
      4'h7: begin e.typ = 2'd2; e.cls = 3'd5; end
      4'h8: begin e.typ = 2'd2; e.cls = 3'd6; end
      4'h4: begin e.typ = 2'd3; e.cls = 3'd7; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic drive(input logic v, input logic [15:0] ins, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    flush_i       = fl;
  endtask

  task automatic push(input logic [15:0] ins);
    exp_t e;
    e = ref_dec(ins);
    if (TRAP && e.ill) begin
      m_trap = 1'b1;
    end else begin
      q.push_back(e);
      if (e.cls == 3'd5) begin
        e.uop = 1'b1;
        q.push_back(e);
      end
    end
  endtask

  task automatic check_out();
    chk("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_instr", bus.out_instr, q[0].instr);
      chk("out_type",  bus.out_type,  q[0].typ);
      chk("out_cls",   bus.out_cls,   q[0].cls);
      chk("out_uop",   bus.out_uop,   q[0].uop);
      chk("illegal_o", bus.illegal_o, q[0].ill);
    end
    chk("dec_count", bus.dec_count, m_cnt);
    chk("trap_o", bus.trap_o, m_trap);
  endtask

  // One clock: predict handshake from the scoreboard, advance, update model, compare
  task automatic cyc();
    bit acc, con, exp_rdy;
    #1;
    exp_rdy = (q.size() == 0 || bus.out_ready) && (q.size() < 2) && !flush_i;
    chk("in_ready", bus.in_ready, exp_rdy);
    acc = bus.in_valid && exp_rdy;
    con = (q.size() > 0) && bus.out_ready && !flush_i;
    @(posedge clk);
    #1;
    m_trap = 1'b0;
    if (flush_i) begin
      q.delete();
    end else begin
      if (con) begin
        void'(q.pop_front());
        m_cnt++;
      end
      if (acc) push(bus.in_instr);
    end
    check_out();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_instr"}, bus.out_instr, 0);
    chk({tag, "_type"},  bus.out_type, 0);
    chk({tag, "_cls"},   bus.out_cls, 0);
    chk({tag, "_uop"},   bus.out_uop, 0);
    chk({tag, "_ill"},   bus.illegal_o, 0);
    chk({tag, "_trap"},  bus.trap_o, 0);
    chk({tag, "_cnt"},   bus.dec_count, 0);
  endtask

  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 reset_checks(tag);
    q.delete();
    m_cnt  = '0;
    m_trap = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_checks("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain ALU instruction
    drive(1'b1, 16'h1234, 1'b1, 1'b0); cyc();
    drive(1'b0, 16'h0, 1'b1, 1'b0);    repeat (2) cyc();

    // CALL split into two micro-ops
    drive(1'b1, 16'h7040, 1'b1, 1'b0); cyc();
    drive(1'b0, 16'h0, 1'b1, 1'b0);    repeat (3) cyc();

    // Branch held under back-pressure, next instruction waits then follows with no bubble
    drive(1'b1, 16'h4008, 1'b0, 1'b0); cyc();
    drive(1'b1, 16'h2111, 1'b0, 1'b0); repeat (5) cyc();
    drive(1'b1, 16'h2111, 1'b1, 1'b0); cyc();
    drive(1'b0, 16'h0, 1'b1, 1'b0);    repeat (2) cyc();

    // Flush while in CALL2
    drive(1'b1, 16'h7040, 1'b0, 1'b0); cyc();
    drive(1'b0, 16'h0, 1'b0, 1'b0);    cyc();
    drive(1'b1, 16'h5123, 1'b1, 1'b1); cyc();
    drive(1'b1, 16'h5123, 1'b1, 1'b0); cyc();
    drive(1'b0, 16'h0, 1'b1, 1'b0);    repeat (2) cyc();

    // Illegal opcode
    drive(1'b1, 16'hC000, 1'b1, 1'b0); cyc();
    drive(1'b0, 16'h0, 1'b1, 1'b0);    repeat (3) cyc();

    // Reset while in CALL2: no uop=1 bundle afterwards
    drive(1'b1, 16'h7040, 1'b0, 1'b0); cyc();
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    mid_reset("rst_call2");
    repeat (2) cyc();

    // Mixed traffic with random back-pressure and occasional flush
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
      cyc();
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0); repeat (4) cyc();

    // Counter wrap: 17 back-to-back ALU instructions from reset
    mid_reset("rst_wrap");
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, {4'h1, 12'(i)}, 1'b1, 1'b0);
      cyc();
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0); repeat (2) cyc();
    chk("wrap_final", bus.dec_count, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
